seg_scan_display: RTL

Parametrised, multiplexed seven-segment hex display driver. It replaces the fixed 8-digit `segment` + `clkdiv` pair with a single block that has these features:
- a built-in scan prescaler;
- configurable digit count and output polarity;
- tear-free frame-synchronous data update;
- optional leading-zero blanking, per-digit decimal points and anti-ghosting.

It sits at the top level of the CPU board design and displays a register or debug value on the board's digit array.

---
 rtl/seg_scan_display.sv | 89 ++++++++
 1 files changed

// File: rtl/seg_scan_display.sv
// seg_scan_display: multiplexed hex 7-seg driver with scan prescaler, frame-synchronous update, leading-zero blanking.
// Optional brightness PWM on the digit selects when SEGSCAN_PWM_EN is defined.
module seg_scan_display #(
  parameter int DIGITS = 8,
  parameter int DIV_W = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW = 1'b1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] data_in,
  input  logic [DIGITS-1:0]   dp_in,
  input  logic                load,
  input  logic                blank_lz,
`ifdef SEGSCAN_PWM_EN
  input  logic [3:0]          brightness,
`endif
  output logic [6:0]          a2g,
  output logic                dp,
  output logic [DIGITS-1:0]   an,
  output logic                frame_done
);
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [IW-1:0] TOP = IW'(DIGITS - 1);
  localparam logic [6:0] FONT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
  logic [DIV_W-1:0] pre;
  logic [IW-1:0] idx;
  logic [4*DIGITS-1:0] stg_data, disp_data;
  logic [DIGITS-1:0] stg_dp, disp_dp, lz, sel;
  logic pend, tick, boundary, blank, lit, zero_run;
  logic [3:0] nib;
  logic [6:0] seg;
  assign tick = &pre;
  assign boundary = tick && idx == '0;
  assign nib = disp_data[{idx, 2'b00} +: 4];
  // lz[k] is set when digit k and every more significant digit are zero
  always_comb begin
    lz = '0;
    zero_run = 1'b1;
    for (int j = DIGITS - 1; j >= 0; j--) begin
      zero_run = zero_run && disp_data[4*j +: 4] == 4'd0;
      lz[j] = zero_run;
    end
  end
  assign blank = blank_lz && idx != '0 && lz[idx];
  assign seg = blank ? 7'd0 : FONT[nib];
`ifdef SEGSCAN_PWM_EN
  assign lit = !tick && pre[DIV_W-1 -: 4] <= brightness;
`else
  assign lit = !tick;
`endif
  assign sel = lit ? DIGITS'(1) << idx : '0;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre <= '0;
      idx <= TOP;
      stg_data <= '0;
      stg_dp <= '0;
      disp_data <= '0;
      disp_dp <= '0;
      pend <= 1'b0;
      a2g <= {7{SEG_ACTIVE_LOW}};
      dp <= SEG_ACTIVE_LOW;
      an <= {DIGITS{AN_ACTIVE_LOW}};
      frame_done <= 1'b0;
    end else begin
      pre <= pre + 1'b1;
      if (tick) idx <= idx == '0 ? TOP : idx - 1'b1;
      if (load) begin
        stg_data <= data_in;
        stg_dp <= dp_in;
      end
      // a load on the boundary itself stays pending for the following frame
      pend <= load || (pend && !boundary);
      if (boundary && pend) begin
        disp_data <= stg_data;
        disp_dp <= stg_dp;
      end
      a2g <= seg ^ {7{SEG_ACTIVE_LOW}};
      dp <= disp_dp[idx] ^ SEG_ACTIVE_LOW;
      an <= sel ^ {DIGITS{AN_ACTIVE_LOW}};
      frame_done <= boundary;
    end
  end
endmodule
